// File: rtl/audio_pkg.sv
// Shared audio constants for the codec-side I2S blocks (ADC receiver and DAC
// transmitter): default sample width, slot/frame geometry and the common
// IDLE/RUN state encoding.
package audio_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int SLOT_BITS    = 32;
  localparam int FRAME_BITS   = 64;

  // Serial-port state encoding, kept as plain constants so older blocks that
  // store the state in a bare logic vector stay compatible.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // True when slot position pos carries one of the width sample bits.
  // Position 0 is the I2S one-bit delay; positions past width are padding.
  function automatic logic slot_bit_active(input logic [4:0] pos, input int width);
    return (pos != 5'd0) && (int'(pos) <= width);
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S master timing: divides clk down to BCLK, counts the 64 bit positions of
// a stereo frame and provides single-cycle strobes for each BCLK edge.
// Strobes are asserted in the cycle whose closing clk edge makes the toggle.
module i2s_bclk_gen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  output logic       bclk,
  output logic       lrclk,
  output logic [5:0] bit_cnt,
  output logic       rise_stb,
  output logic       fall_stb
);

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  logic [0:0] state_q, state_d;
  logic [7:0] div_q, div_d;
  logic       bclk_q, bclk_d;
  logic [5:0] bit_cnt_q, bit_cnt_d;
  logic       rise_s, fall_s;

  // Next-state logic: divider, BCLK toggle, bit counter and IDLE/RUN control.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bclk_d    = bclk_q;
    bit_cnt_d = bit_cnt_q;
    rise_s    = 1'b0;
    fall_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        div_d     = 8'd0;
        bclk_d    = 1'b0;
        bit_cnt_d = 6'd0;
        if (en) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (div_q == DIV_MAX) begin
          div_d  = 8'd0;
          bclk_d = ~bclk_q;
          if (bclk_q) begin
            // Falling toggle: advance to the next bit position. Leaving RUN
            // is only allowed at the frame wrap so a started frame finishes.
            fall_s    = 1'b1;
            bit_cnt_d = bit_cnt_q + 6'd1;
            if ((bit_cnt_q == 6'd63) && !en) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            rise_s  = 1'b1;
            state_d = ST_RUN;
          end
        end else begin
          div_d   = div_q + 8'd1;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        div_d     = 8'd0;
        bclk_d    = 1'b0;
        bit_cnt_d = 6'd0;
      end
    endcase
  end

  // Timing registers; reset returns to IDLE with BCLK and counters cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      div_q     <= 8'd0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= 6'd0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bclk     = bclk_q;
  assign lrclk    = bit_cnt_q[5];
  assign bit_cnt  = bit_cnt_q;
  assign rise_stb = rise_s;
  assign fall_stb = fall_s;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver for a slave codec ADC: drives BCLK/ADCLRCLK, deserialises the
// left and right slots and presents complete stereo pairs through a
// valid/ready handshake. Frames arriving while a pair is still unaccepted
// are dropped and flagged by the sticky overrun bit.
module i2s_rx
  import audio_pkg::*;
#(
  parameter int CLK_DIV  = 8,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                ADCDAT,
  output logic                BCLK,
  output logic                ADCLRCLK,
  output logic [SAMPLE_W-1:0] sample_l,
  output logic [SAMPLE_W-1:0] sample_r,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun
);

  logic [5:0] bit_cnt_s;
  logic       rise_s, fall_s;
  logic [4:0] pos_s;
  logic       capture_s, slot_start_s;

  logic                adc_q;
  logic [SAMPLE_W-1:0] shift_l_q, shift_l_d;
  logic [SAMPLE_W-1:0] shift_r_q, shift_r_d;
  logic                frame_done_q, frame_done_d;
  logic [SAMPLE_W-1:0] sample_l_q, sample_l_d;
  logic [SAMPLE_W-1:0] sample_r_q, sample_r_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;

  i2s_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .bclk     (BCLK),
    .lrclk    (ADCLRCLK),
    .bit_cnt  (bit_cnt_s),
    .rise_stb (rise_s),
    .fall_stb (fall_s)
  );

  assign pos_s        = bit_cnt_s[4:0];
  assign capture_s    = rise_s && slot_bit_active(pos_s, SAMPLE_W);
  // The falling toggle out of position 31 opens the next slot.
  assign slot_start_s = fall_s && (pos_s == 5'd31);

  // Shift-register update: sample bits enter MSB first on the BCLK rise; the
  // register of the slot about to start is cleared so it holds only new bits.
  always_comb begin
    shift_l_d    = shift_l_q;
    shift_r_d    = shift_r_q;
    frame_done_d = 1'b0;
    if (capture_s) begin
      if (bit_cnt_s[5]) begin
        shift_r_d    = {shift_r_q[SAMPLE_W-2:0], adc_q};
        frame_done_d = (pos_s == 5'(SAMPLE_W));
      end else begin
        shift_l_d = {shift_l_q[SAMPLE_W-2:0], adc_q};
      end
    end else if (slot_start_s) begin
      if (bit_cnt_s[5]) begin
        shift_l_d = '0;
      end else begin
        shift_r_d = '0;
      end
    end else begin
      frame_done_d = 1'b0;
    end
  end

  // Output register and handshake: a completed frame loads when the holding
  // register is free or being accepted this cycle, otherwise it is dropped.
  always_comb begin
    sample_l_d = sample_l_q;
    sample_r_d = sample_r_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    if (frame_done_q) begin
      if (!valid_q || out_ready) begin
        sample_l_d = shift_l_q;
        sample_r_d = shift_r_q;
        valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Datapath registers; reset discards any partial frame and the held pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adc_q        <= 1'b0;
      shift_l_q    <= '0;
      shift_r_q    <= '0;
      frame_done_q <= 1'b0;
      sample_l_q   <= '0;
      sample_r_q   <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      adc_q        <= ADCDAT;
      shift_l_q    <= shift_l_d;
      shift_r_q    <= shift_r_d;
      frame_done_q <= frame_done_d;
      sample_l_q   <= sample_l_d;
      sample_r_q   <= sample_r_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sample_l  = sample_l_q;
  assign sample_r  = sample_r_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: a codec model serialises stereo words on BCLK, a
// transaction-level model predicts the held pair, out_valid and overrun,
// and directed scenarios pin the model with literal expectations.
module tb_i2s_rx;

  localparam int DIV = 2;
  localparam int W   = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         en;
  logic         ADCDAT;
  logic         out_ready;
  logic         BCLK;
  logic         ADCLRCLK;
  logic         out_valid;
  logic         overrun;
  logic [W-1:0] sample_l;
  logic [W-1:0] sample_r;

  always #10 clk = ~clk;

  i2s_rx #(.CLK_DIV(DIV), .SAMPLE_W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .ADCDAT    (ADCDAT),
    .BCLK      (BCLK),
    .ADCLRCLK  (ADCLRCLK),
    .sample_l  (sample_l),
    .sample_r  (sample_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- codec model (I2S slave) ----------------
  int           cpos = 0;
  logic [W-1:0] cur_l = '0;
  logic [W-1:0] cur_r = '0;
  logic [W-1:0] q_l[$];
  logic [W-1:0] q_r[$];

  function automatic logic codec_bit(input int pos, input logic [W-1:0] l, input logic [W-1:0] r);
    int p;
    logic [W-1:0] w;
    p = pos % 32;
    w = (pos >= 32) ? r : l;
    if (p >= 1 && p <= W) return w[W-p];
    return 1'b1;  // padding / delay bit: deliberately 1 so it must be ignored
  endfunction

  assign ADCDAT = codec_bit(cpos, cur_l, cur_r);

  always @(negedge BCLK or negedge reset_n) begin
    if (!reset_n) begin
      cpos = 0;
    end else begin
      cpos = (cpos + 1) % 64;
      if (cpos == 0 && q_l.size() > 0) begin
        cur_l = q_l.pop_front();
        cur_r = q_r.pop_front();
      end
    end
  end

  task automatic push(input logic [W-1:0] l, input logic [W-1:0] r);
    q_l.push_back(l);
    q_r.push_back(r);
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  logic         m_valid = 1'b0;
  logic         m_ovr   = 1'b0;
  logic [W-1:0] m_l     = '0;
  logic [W-1:0] m_r     = '0;
  logic         prev_b  = 1'b0;
  logic         m_done;
  int           frames_done = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_valid = 1'b0; m_ovr = 1'b0; m_l = '0; m_r = '0; prev_b = 1'b0;
    end
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("sample_l", 32'(sample_l), 32'(m_l));
    chk("sample_r", 32'(sample_r), 32'(m_r));
    chk("lrclk", 32'(ADCLRCLK), 32'(cpos >= 32));
    if (reset_n) begin
      // A frame is complete once the last right-slot bit has been clocked in.
      m_done = BCLK && !prev_b && (cpos == 32 + W);
      prev_b = BCLK;
      if (m_done) begin
        frames_done++;
        if (!m_valid || out_ready) begin
          m_valid = 1'b1; m_l = cur_l; m_r = cur_r;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_wait();
    @(posedge clk);
    #2;
  endtask

  // Returns on the negedge right after the n-th frame has loaded/dropped.
  task automatic wait_frames(input int n);
    int t = 0;
    while (frames_done < n && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk("wait_frames", 32'(frames_done >= n), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_cpos(input int v);
    int t = 0;
    @(negedge clk);
    while (cpos != v && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_cpos", 32'(cpos == v), 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  time t1, t2;
  int  bad;

  initial begin
    reset_n = 1'b0; en = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bclk", 32'(BCLK), 32'd0);
    chk("rst_lrclk", 32'(ADCLRCLK), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_l", 32'(sample_l), 32'd0);
    chk("rst_r", 32'(sample_r), 32'd0);
    drive_wait(); reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_bclk", 32'(BCLK), 32'd0);

    // Basic frame with consumer always ready.
    cur_l = 16'hA5C3; cur_r = 16'h1234;
    push(16'h8000, 16'h7FFF); push(16'h8000, 16'h7FFF);
    drive_wait(); en = 1'b1;
    wait_frames(1);
    chk("f1_l", 32'(sample_l), 32'h0000A5C3);
    chk("f1_r", 32'(sample_r), 32'h00001234);
    chk("f1_valid", 32'(out_valid), 32'd1);
    chk("f1_ovr", 32'(overrun), 32'd0);
    chk("model_l", 32'(m_l), 32'h0000A5C3);
    @(negedge clk);
    chk("f1_pulse", 32'(out_valid), 32'd0);

    // Extreme values, BCLK period, frame spacing.
    wait_frames(2);
    t1 = $time;
    chk("f2_l", 32'(sample_l), 32'h00008000);
    chk("f2_r", 32'(sample_r), 32'h00007FFF);
    wait_frames(3);
    t2 = $time;
    chk("frame_spacing", 32'((t2 - t1) / 20), 32'd256);
    chk("f3_l", 32'(sample_l), 32'h00008000);
    @(posedge BCLK); t1 = $time;
    @(posedge BCLK); t2 = $time;
    chk("bclk_period", 32'((t2 - t1) / 20), 32'd4);

    // Handshake in the same cycle a new frame loads.
    drive_wait(); out_ready = 1'b0;
    push(16'h0005, 16'h0006); push(16'h0007, 16'h0008);
    wait_frames(4);
    chk("f4_l", 32'(sample_l), 32'h00000005);
    repeat (5) @(negedge clk);
    chk("f4_hold", 32'(out_valid), 32'd1);
    wait_cpos(32 + W);
    bad = 0;
    do begin
      @(posedge clk); #2; bad++;
    end while (!BCLK && bad < 16);
    out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("same_valid", 32'(out_valid), 32'd1);
    chk("same_l", 32'(sample_l), 32'h00000007);
    chk("same_r", 32'(sample_r), 32'h00000008);
    chk("same_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    chk("same_accept", 32'(out_valid), 32'd0);

    // Consumer stalls for three frames.
    drive_wait(); out_ready = 1'b0;
    push(16'h0001, 16'h0001); push(16'h0002, 16'h0002);
    push(16'h0003, 16'h0003); push(16'h0004, 16'h0004);
    wait_frames(6);
    chk("st1_l", 32'(sample_l), 32'h00000001);
    chk("st1_ovr", 32'(overrun), 32'd0);
    wait_frames(7);
    chk("st2_l", 32'(sample_l), 32'h00000001);
    chk("st2_ovr", 32'(overrun), 32'd1);
    wait_frames(8);
    chk("st3_r", 32'(sample_r), 32'h00000001);
    chk("st3_valid", 32'(out_valid), 32'd1);
    drive_wait(); out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("st_accept", 32'(out_valid), 32'd0);
    wait_frames(9);
    chk("st_fresh", 32'(sample_l), 32'h00000004);
    chk("st_ovr_sticky", 32'(overrun), 32'd1);

    // en dropped mid left slot: frame completes, then idle.
    push(16'h1111, 16'h2222);
    wait_cpos(20);
    drive_wait(); en = 1'b0;
    push(16'h3333, 16'h4444);
    wait_frames(10);
    chk("en_l", 32'(sample_l), 32'h00001111);
    chk("en_r", 32'(sample_r), 32'h00002222);
    repeat (80) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (BCLK !== 1'b0 || ADCLRCLK !== 1'b0) bad++;
    end
    chk("idle_hold", 32'(bad), 32'd0);
    chk("idle_frames", 32'(frames_done), 32'd10);
    drive_wait(); en = 1'b1;
    wait_frames(11);
    chk("re_l", 32'(sample_l), 32'h00003333);
    chk("re_r", 32'(sample_r), 32'h00004444);

    // Reset mid right slot.
    push(16'h5555, 16'h6666);
    wait_cpos(40);
    drive_wait(); reset_n = 1'b0;
    #1;
    chk("arst_l", 32'(sample_l), 32'd0);
    chk("arst_r", 32'(sample_r), 32'd0);
    chk("arst_ovr", 32'(overrun), 32'd0);
    chk("arst_bclk", 32'(BCLK), 32'd0);
    repeat (3) @(negedge clk);
    cur_l = 16'h7777; cur_r = 16'h8888;
    drive_wait(); reset_n = 1'b1;
    wait_frames(12);
    chk("post_l", 32'(sample_l), 32'h00007777);
    chk("post_r", 32'(sample_r), 32'h00008888);
    chk("post_ovr", 32'(overrun), 32'd0);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter CLK_DIV, default 8, clk cycles per BCLK half-period; legal range 2..255.
REQ-002 Parameter SAMPLE_W, default 16, bits captured per channel; legal range 8..24.
REQ-003 clk  input  1  system clock, 50 MHz; the only clock; every flop is on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 en  input  1  capture enable; sampled only at frame boundaries.
REQ-006 ADCDAT  input  1  serial data from the codec ADC.
REQ-007 BCLK  output  1  bit clock driven to the codec; the codec is the I2S slave.
REQ-008 ADCLRCLK  output  1  channel select: 0 = left slot, 1 = right slot.
REQ-009 sample_l  output  SAMPLE_W  last complete left sample, two's complement.
REQ-010 sample_r  output  SAMPLE_W  last complete right sample, two's complement.
REQ-011 out_valid  output  1  a stereo pair is held on sample_l/sample_r.
REQ-012 out_ready  input  1  the consumer accepts the pair.
REQ-013 overrun  output  1  sticky flag: a frame was dropped.

Function
REQ-014 Divider: counts 0..CLK_DIV-1; on wrap it toggles BCLK; BCLK period = 2*CLK_DIV clk cycles.
REQ-015 Bit counter: 6 bits, 0..63; increments on each BCLK falling toggle; wraps 63->0; ADCLRCLK = bit_cnt[5].
REQ-016 Slot position p = bit_cnt[4:0]; at p=0 the data is ignored (I2S one-bit delay); p=1..SAMPLE_W carry the sample MSB first; later bits are ignored.
REQ-017 ADCDAT is registered once per clk; the registered value is shifted into the channel shift register in the clk cycle that BCLK toggles 0->1.
REQ-018 Right-slot capture of p=SAMPLE_W completes a frame; on the next clk the pair is loaded into sample_l/sample_r and out_valid=1.
REQ-019 Handshake: out_valid stays high and the data stays stable until the consumer sees out_valid&out_ready at a clk edge; out_valid falls on the following clk unless a new frame loads in that same cycle.
REQ-020 New frame with out_valid=1 and out_ready=0: the new frame is dropped, the outputs keep the old pair, and overrun is set.
REQ-021 A frame completing in the same cycle as the out_valid&out_ready handshake: the new pair loads, out_valid stays 1, and overrun is not set.
REQ-022 overrun clears only on reset.
REQ-023 State machine IDLE/RUN.
  - IDLE: BCLK=0, ADCLRCLK=0, counters at 0; moves to RUN on the first clk with en=1.
  - RUN: moves back to IDLE only at the bit_cnt 63->0 wrap with en=0, so a frame that has started always completes.
REQ-024 No partial frame is ever presented on the outputs.

Reset
REQ-025 With reset_n low, the state is IDLE and BCLK, ADCLRCLK, out_valid, overrun, sample_l, sample_r, the divider, bit_cnt and both shift registers are all 0.
REQ-026 Reset asserted mid-frame discards the partial frame immediately; after release, capture restarts at bit_cnt 0 once en=1.

Structure
REQ-027 Shared package audio_pkg holds the SAMPLE_W default, SLOT_BITS=32, the FRAME_BITS=64 constants and the IDLE/RUN state encoding; the DAC-side transmitter uses the same package.
REQ-028 One sub-module, i2s_bclk_gen, generates BCLK, ADCLRCLK, bit_cnt and the one-cycle rise/fall strobes; i2s_rx contains the shift registers, the output register and the handshake.

Verification
REQ-029 Codec model shifts left 0xA5C3, right 0x1234 with out_ready=1 -> sample_l=0xA5C3, sample_r=0x1234, out_valid high 1 cycle, overrun=0.
REQ-030 Extremes: left 0x8000, right 0x7FFF with CLK_DIV=2 -> values exact; BCLK period = 4 clk cycles; one out_valid per 256 clk cycles.
REQ-031 out_ready=0 for 3 frames (0x0001, 0x0002, 0x0003) -> the outputs hold frame 0x0001 and overrun=1 after frame 2; then out_ready=1 -> 0x0001 is accepted, followed by the next fresh frame.
REQ-032 en dropped at bit_cnt=20 of the left slot -> the frame completes, out_valid pulses, then BCLK=0 and ADCLRCLK=0 until en returns.
REQ-033 reset_n pulsed low at bit_cnt=40 -> the outputs go to 0 asynchronously, no stale pair is emitted, and the first frame after release is captured correctly.
REQ-034 Handshake taken in the same cycle a new frame loads -> out_valid stays 1, the new pair is presented, and overrun=0.
